// File: rtl/cond_compare_pipe.sv
// Pipelined A-B comparator: NZCV flags, signed/unsigned relationals and ARM
// condition evaluation, with valid/ready backpressure and a pass-through tag.
module cond_compare_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic [3:0]       cond,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       flags,
  output logic             cond_true,
  output logic             eq,
  output logic             neq,
  output logic             lt,
  output logic             lte,
  output logic             gt,
  output logic             gte,
  output logic [TAG_W-1:0] tag_out
);

  localparam int L = STAGES - 1;

  logic [WIDTH:0] w_diff;
  logic           w_n_in, w_z_in, w_c_in, w_v_in;
  logic           w_advance;

  logic             r_valid [STAGES];
  logic [3:0]       r_flags [STAGES];
  logic             r_mode  [STAGES];
  logic [3:0]       r_cond  [STAGES];
  logic [TAG_W-1:0] r_tag   [STAGES];

  assign w_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_n_in = w_diff[WIDTH-1];
  assign w_z_in = (w_diff[WIDTH-1:0] == '0);
  assign w_c_in = w_diff[WIDTH];
  assign w_v_in = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign w_advance = !r_valid[L] || out_ready;
  assign in_ready  = w_advance;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        r_valid[i] <= 1'b0;
        r_flags[i] <= '0;
        r_mode[i]  <= 1'b0;
        r_cond[i]  <= '0;
        r_tag[i]   <= '0;
      end
    end else if (w_advance) begin
      r_valid[0] <= in_valid;
      r_flags[0] <= {w_n_in, w_z_in, w_c_in, w_v_in};
      r_mode[0]  <= signed_mode;
      r_cond[0]  <= cond;
      r_tag[0]   <= tag_in;
      for (int i = 1; i < STAGES; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_flags[i] <= r_flags[i-1];
        r_mode[i]  <= r_mode[i-1];
        r_cond[i]  <= r_cond[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  logic w_n, w_z, w_c, w_v, w_lt, w_gt, w_cond;
  logic w_vld;

  assign w_vld = r_valid[L];
  assign w_n   = r_flags[L][3];
  assign w_z   = r_flags[L][2];
  assign w_c   = r_flags[L][1];
  assign w_v   = r_flags[L][0];

  assign w_lt = r_mode[L] ? (w_n ^ w_v) : !w_c;
  assign w_gt = r_mode[L] ? (!w_z && !(w_n ^ w_v)) : (w_c && !w_z);

  always_comb begin
    w_cond = 1'b1;
    case (r_cond[L])
      4'h0:    w_cond = w_z;
      4'h1:    w_cond = !w_z;
      4'h2:    w_cond = w_c;
      4'h3:    w_cond = !w_c;
      4'h4:    w_cond = w_n;
      4'h5:    w_cond = !w_n;
      4'h6:    w_cond = w_v;
      4'h7:    w_cond = !w_v;
      4'h8:    w_cond = w_c && !w_z;
      4'h9:    w_cond = !w_c || w_z;
      4'hA:    w_cond = (w_n == w_v);
      4'hB:    w_cond = (w_n != w_v);
      4'hC:    w_cond = !w_z && (w_n == w_v);
      4'hD:    w_cond = w_z || (w_n != w_v);
      default: w_cond = 1'b1;
    endcase
  end

  // Data outputs read as zero whenever no result is presented.
  assign out_valid = w_vld;
  assign flags     = w_vld ? r_flags[L] : 4'b0000;
  assign tag_out   = w_vld ? r_tag[L] : '0;
  assign cond_true = w_vld && w_cond;
  assign eq        = w_vld && w_z;
  assign neq       = w_vld && !w_z;
  assign lt        = w_vld && w_lt;
  assign gte       = w_vld && !w_lt;
  assign gt        = w_vld && w_gt;
  assign lte       = w_vld && !w_gt;

endmodule

// File: doc/cond_compare_pipe.md
Name: cond_compare_pipe

Overview:
Parametrised, pipelined successor to the combinational `comparator`. Computes A−B once and produces:
- the six relational outputs (eq, neq, lt, lte, gt, gte) in either signed or unsigned mode;
- ARM NZCV flags;
- evaluation of a 4-bit ARM condition code.

It sits between the decode/register-read stage and the branch/predication logic. It uses a valid/ready handshake with backpressure and carries a tag through unchanged.

Parameters:
- WIDTH, 32, operand width in bits (≥2)
- STAGES, 2, pipeline depth in cycles from acceptance to out_valid (1..4)
- TAG_W, 5, width of the pass-through tag (e.g. destination/ROB id)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- signed_mode  in  1  1 = relational outputs are signed, 0 = unsigned
- cond  in  4  ARM condition code to evaluate
- tag_in  in  TAG_W  opaque tag
- out_valid  out  1  result present at last stage
- out_ready  in  1  consumer accepts the result
- flags  out  4  {N,Z,C,V} of A−B
- cond_true  out  1  cond satisfied by flags
- eq, neq, lt, lte, gt, gte  out  1 each  relational results per signed_mode
- tag_out  out  TAG_W  tag of the current result

Behaviour:
- Reset:
  - asynchronous, active-high; all stage valid bits clear.
  - All outputs go to 0 (flags=4'b0000, cond_true=0, relational outputs=0, tag_out=0, out_valid=0).
  - in_ready=1 once reset deasserts.
  - Any in-flight transactions are discarded with no output.
- Handshake:
  - transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - `advance` = !out_valid || out_ready. in_ready = advance, combinational from out_ready and the last-stage valid.
  - When advance=1, every stage shifts by one. When advance=0, all stages hold and outputs stay stable.
  - No bubble collapsing: a bubble only leaves when the whole pipe advances.
- Stage 1 arithmetic:
  - diff = a + ~b + 1, computed at WIDTH+1 bits.
  - C = carry out of the sum (1 means no borrow, i.e. a ≥ b unsigned).
  - N = diff[WIDTH-1]; Z = (diff[WIDTH-1:0] == 0).
  - V = (a[msb] != b[msb]) && (diff[msb] != a[msb]).
- Relational outputs (computed from the registered flags):
  - eq = Z; neq = !Z.
  - Signed: lt = N^V; gte = !lt; gt = !Z && !(N^V); lte = !gt.
  - Unsigned: lt = !C; gte = C; gt = C && !Z; lte = !gt.
- Condition decode:
  - 0 EQ: Z; 1 NE: !Z; 2 CS: C; 3 CC: !C; 4 MI: N; 5 PL: !N; 6 VS: V; 7 VC: !V.
  - 8 HI: C&&!Z; 9 LS: !C||Z; A GE: N==V; B LT: N!=V; C GT: !Z&&N==V; D LE: Z||N!=V.
  - E AL: 1; F: 1 (treated as always).
- Latency: exactly STAGES cycles from the accepting edge to out_valid=1 when unstalled.
  - Throughput is one result per cycle.
  - Results leave in order of acceptance.
- When out_valid=0, all data outputs are 0 (masked by valid).
- Simultaneous accept on input and output in the same cycle is legal and required for full throughput.
- STAGES=1: registered flags and tag drive the outputs directly.

Test Plan:
- a=5, b=5, cond=0 (EQ), signed_mode=0 → after STAGES cycles: flags=0110 (Z=1, C=1), cond_true=1, eq=1, lte=1, gte=1, lt=0, gt=0.
- a=0x80000000, b=1, cond=B (LT), signed_mode=1 → flags N=0, Z=0, C=1, V=1; cond_true=1, lt=1. Same operands with signed_mode=0 → gt=1, lt=0.
- Stream of 28 back-to-back pairs, starting (2648,5357), (9874,9875), (5580,5579), (7433,7433), with cond=3 (CC) and out_ready=1 → one result per cycle, in order, tags 0..27 preserved; cond_true = (a < b).
- Send 4 transactions and hold out_ready=0 for 3 cycles → in_ready=0 while the pipe is full; outputs stay frozen; after release, all 4 results emerge with no loss or duplication.
- Assert reset asynchronously mid-stream (between clock edges) → out_valid, flags and relational outputs drop to 0 immediately; no stale result appears after reset releases.
- cond=E and cond=F with a=0, b=0xFFFFFFFF → cond_true=1 in both cases; flags=0000 (C=0: borrow).
